// File: rtl/operand_fetcher.sv
// Operand fetch stage: turns weight/IF read requests into memory address/enable
// bursts, returns the fetched words with row indices and holds the bank select.

module operand_fetch_engine #(
  parameter int LEN   = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     read,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     en,
  output logic                     valid,
  output logic [$clog2(LEN)-1:0]   row,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] base, base_nx;

  // State register, plus the one-cycle-delayed output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      base  <= '0;
      valid <= 1'b0;
      row   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      base  <= base_nx;
      valid <= en;
      row   <= cnt;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    base_nx  = base;
    case (state)
      S_IDLE: begin
        if (read) begin
          state_nx = S_FETCH;
          cnt_nx   = '0;
        end
      end
      S_FETCH: begin
        if (cnt == CW'(LEN - 1)) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        state_nx = S_IDLE;
        base_nx  = (base == AW'(DEPTH - LEN)) ? '0 : base + AW'(LEN);
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    // Clear overrides everything, including a read seen in the same cycle.
    if (clr) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      base_nx  = '0;
    end
  end

  // base never exceeds DEPTH-LEN, so base+cnt stays inside the memory.
  always_comb begin
    en        = (state == S_FETCH);
    done      = (state == S_DRAIN);
    addr      = base + AW'(cnt);
    state_dbg = state;
  end

endmodule

module operand_fetcher #(
  parameter int DW       = 8,
  parameter int ROWS     = 8,
  parameter int IF_LEN   = 16,
  parameter int W_DEPTH  = 256,
  parameter int IF_DEPTH = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_read,
  input  logic                        clr_w,
  input  logic                        if_read,
  input  logic                        clr_if,
  input  logic                        switch,
  output logic [$clog2(W_DEPTH)-1:0]  w_addr,
  output logic                        w_en,
  input  logic [DW-1:0]               w_rdata,
  output logic                        w_valid,
  output logic [DW-1:0]               w_data,
  output logic [$clog2(ROWS)-1:0]     w_row,
  output logic                        w_done,
  output logic [$clog2(IF_DEPTH)-1:0] if_addr,
  output logic                        if_en,
  input  logic [DW-1:0]               if_rdata,
  output logic                        if_valid,
  output logic [DW-1:0]               if_data,
  output logic [$clog2(IF_LEN)-1:0]   if_row,
  output logic                        if_done,
  output logic                        bank,
  output logic [1:0]                  w_state,
  output logic [1:0]                  if_state
);

  // Output streams are valid-only: a word is presented for exactly one cycle
  // while *_valid is high and there is no backpressure from the array.
  operand_fetch_engine #(.LEN(ROWS), .DEPTH(W_DEPTH)) u_w_eng (
    .clk       (clk),
    .rst_n     (rst),
    .read      (w_read),
    .clr       (clr_w),
    .addr      (w_addr),
    .en        (w_en),
    .valid     (w_valid),
    .row       (w_row),
    .done      (w_done),
    .state_dbg (w_state)
  );

  operand_fetch_engine #(.LEN(IF_LEN), .DEPTH(IF_DEPTH)) u_if_eng (
    .clk       (clk),
    .rst_n     (rst),
    .read      (if_read),
    .clr       (clr_if),
    .addr      (if_addr),
    .en        (if_en),
    .valid     (if_valid),
    .row       (if_row),
    .done      (if_done),
    .state_dbg (if_state)
  );

  assign w_data  = w_rdata;
  assign if_data = if_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank <= 1'b0;
    end else if (switch) begin
      bank <= ~bank;
    end
  end

endmodule
